// File: rtl/pipe_stage.sv
// Inter-stage pipeline register: payload, write-back address, PC, delay-slot flag and
// merged exception code, with stall/flush control and saturating stall/bubble counters.
module pipe_stage #(
    parameter int DATA_W = 128,
    parameter int WBA_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [WBA_W-1:0]  in_wba,
    input  logic [31:0]       in_pc,
    input  logic              in_bd,
    input  logic [4:0]        in_exc,
    input  logic [4:0]        stage_exc,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [WBA_W-1:0]  out_wba,
    output logic [31:0]       out_pc,
    output logic              out_bd,
    output logic [4:0]        out_exc,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [WBA_W-1:0]  wba_q, wba_d;
    logic [31:0]       pc_q, pc_d;
    logic              bd_q, bd_d;
    logic [4:0]        exc_q, exc_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic [4:0] exc_merge;
    logic       stall_inc, bubble_inc;

    // Earliest stage's exception wins; an empty slot carries none.
    always_comb begin
        exc_merge = 5'd0;
        if (in_valid)
            exc_merge = (in_exc != 5'd0) ? in_exc : stage_exc;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        wba_d   = wba_q;
        pc_d    = pc_q;
        bd_d    = bd_q;
        exc_d   = exc_q;
        if (flush) begin
            // A bubble keeps PC/BD so an interrupt taken here still has a valid EPC.
            valid_d = 1'b0;
            data_d  = '0;
            wba_d   = '0;
            exc_d   = 5'd0;
            pc_d    = in_pc;
            bd_d    = in_bd;
        end else if (en) begin
            valid_d = in_valid;
            data_d  = in_valid ? in_data : '0;
            wba_d   = (in_valid && exc_merge == 5'd0) ? in_wba : '0;
            pc_d    = in_pc;
            bd_d    = in_bd;
            exc_d   = exc_merge;
        end
    end

    assign stall_inc  = !flush && !en && valid_q;
    assign bubble_inc = flush || (en && !in_valid);

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (clr_cnt) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (stall_inc && stall_q != {CNT_W{1'b1}})
                stall_d = stall_q + CNT_W'(1);
            if (bubble_inc && bubble_q != {CNT_W{1'b1}})
                bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            wba_q    <= '0;
            pc_q     <= '0;
            bd_q     <= 1'b0;
            exc_q    <= 5'd0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            wba_q    <= wba_d;
            pc_q     <= pc_d;
            bd_q     <= bd_d;
            exc_q    <= exc_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_wba    = wba_q;
    assign out_pc     = pc_q;
    assign out_bd     = bd_q;
    assign out_exc    = exc_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboarded bench for pipe_stage: directed scenarios plus random traffic,
// expected register contents computed from the stage rules and checked each cycle.
module tb_pipe_stage;

    localparam int DW   = 128;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0, flush = 1'b0, clr_cnt = 1'b0, in_valid = 1'b0, in_bd = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [4:0]    in_wba = '0, in_exc = '0, stage_exc = '0;
    logic [31:0]   in_pc = '0;
    logic          out_valid, out_bd;
    logic [DW-1:0] out_data;
    logic [4:0]    out_wba, out_exc;
    logic [31:0]   out_pc;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    pipe_stage #(.DATA_W(DW), .WBA_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_data(in_data), .in_wba(in_wba), .in_pc(in_pc),
        .in_bd(in_bd), .in_exc(in_exc), .stage_exc(stage_exc),
        .out_valid(out_valid), .out_data(out_data), .out_wba(out_wba), .out_pc(out_pc),
        .out_bd(out_bd), .out_exc(out_exc), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [4:0]    wba;
        logic [31:0]   pc;
        logic          bd;
        logic [4:0]    exc;
        int            sc;
        int            bc;
    } st_t;

    st_t model;
    st_t q[$];
    int  tests = 0, fails = 0;

    function automatic int sat_inc(int x);
        return (x >= CMAX) ? CMAX : x + 1;
    endfunction

    // Next register contents from the stage rules applied to the current inputs.
    function automatic st_t next_state(st_t s);
        st_t n = s;
        int  e;
        if (flush) begin
            n.v = 0; n.d = '0; n.wba = '0; n.exc = '0;
            n.pc = in_pc; n.bd = in_bd;
            n.bc = sat_inc(s.bc);
        end else if (!en) begin
            if (s.v) n.sc = sat_inc(s.sc);
        end else begin
            if (!in_valid)          e = 0;
            else if (in_exc != 0)   e = in_exc;
            else                    e = stage_exc;
            n.v   = in_valid;
            n.d   = in_valid ? in_data : '0;
            n.exc = 5'(e);
            n.wba = (in_valid && e == 0) ? in_wba : 5'd0;
            n.pc  = in_pc;
            n.bd  = in_bd;
            if (!in_valid) n.bc = sat_inc(s.bc);
        end
        if (clr_cnt) begin n.sc = 0; n.bc = 0; end
        return n;
    endfunction

    function automatic st_t zero_state();
        st_t z;
        z.v = 0; z.d = '0; z.wba = '0; z.pc = '0; z.bd = 0; z.exc = '0; z.sc = 0; z.bc = 0;
        return z;
    endfunction

    task automatic check_state(string name, st_t e);
        tests++;
        if (out_valid !== e.v || out_data !== e.d || out_wba !== e.wba || out_pc !== e.pc ||
            out_bd !== e.bd || out_exc !== e.exc || stall_cnt !== 4'(e.sc) || bubble_cnt !== 4'(e.bc)) begin
            fails++;
            $display("FAIL %s: got v=%0b d=%h wba=%0d pc=%h bd=%0b exc=%0d sc=%0d bc=%0d, want v=%0b d=%h wba=%0d pc=%h bd=%0b exc=%0d sc=%0d bc=%0d",
                     name, out_valid, out_data, out_wba, out_pc, out_bd, out_exc, stall_cnt, bubble_cnt,
                     e.v, e.d, e.wba, e.pc, e.bd, e.exc, e.sc, e.bc);
        end
    endtask

    // Monitor: after each edge the registers must match the oldest outstanding prediction.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) check_state("cycle", q.pop_front());
    end

    // Called at a falling edge with inputs already set; predicts the next edge.
    task automatic tick();
        model = next_state(model);
        q.push_back(model);
        @(negedge clk);
    endtask

    task automatic set_in(logic v, logic [DW-1:0] d, logic [4:0] w, logic [31:0] pc,
                          logic bd, logic [4:0] ie, logic [4:0] se, logic e, logic f, logic c);
        in_valid = v; in_data = d; in_wba = w; in_pc = pc; in_bd = bd;
        in_exc = ie; stage_exc = se; en = e; flush = f; clr_cnt = c;
    endtask

    task automatic async_reset(string name);
        reset = 1'b0;
        #1;
        model = zero_state();
        check_state(name, model);
        @(negedge clk);
        check_state({name, "_held"}, model);
        reset = 1'b1;
    endtask

    logic [DW-1:0] a5;

    initial begin
        a5 = {(DW/8){8'hA5}};
        model = zero_state();
        // Reset between edges with every input nonzero.
        set_in(1, {DW{1'b1}}, 5'd31, 32'hFFFF_FFFF, 1, 5'd3, 5'd7, 1, 0, 0);
        #2;
        async_reset("reset_async");

        set_in(1, a5, 5'd8, 32'h3000, 0, 0, 0, 1, 0, 0);      tick();
        // Stall three edges while the inputs keep changing.
        set_in(1, 128'h1234, 5'd9, 32'h3004, 0, 0, 0, 1, 0, 0); tick();
        set_in(1, 128'h5555, 5'd2, 32'h3008, 1, 0, 0, 0, 0, 0); tick();
        set_in(0, 128'h6666, 5'd3, 32'h300C, 0, 0, 5'd1, 0, 0, 0); tick();
        set_in(1, 128'h7777, 5'd4, 32'h3010, 1, 0, 0, 0, 0, 0); tick();
        en = 1'b1;                                             tick();
        // Flush while stalled.
        set_in(1, 128'h9999, 5'd5, 32'h3010, 1, 5'd2, 0, 0, 1, 0); tick();
        // Exception merge cases.
        set_in(1, 128'hAAAA, 5'd9, 32'h3014, 0, 5'd4, 5'd12, 1, 0, 0); tick();
        set_in(1, 128'hBBBB, 5'd9, 32'h3018, 0, 5'd0, 5'd12, 1, 0, 0); tick();
        set_in(0, 128'hCCCC, 5'd9, 32'h301C, 0, 5'd0, 5'd12, 1, 0, 0); tick();
        // Saturation: valid instruction then a long stall, then clear during stall.
        set_in(1, 128'hDDDD, 5'd6, 32'h3020, 0, 0, 0, 1, 0, 0); tick();
        en = 1'b0;
        repeat (20) tick();
        clr_cnt = 1'b1;                                        tick();
        clr_cnt = 1'b0;                                        tick();
        // Flush storm drives the bubble counter to saturation.
        flush = 1'b1;
        repeat (18) tick();
        flush = 1'b0;                                          tick();
        async_reset("reset_mid_stall");

        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 7,
                   {$urandom, $urandom, $urandom, $urandom},
                   5'($urandom), $urandom, 1'($urandom),
                   ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                   ($urandom_range(0, 4) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 19) == 0);
            tick();
            if (i == 200) async_reset("reset_random");
        end

        set_in(0, '0, '0, '0, 0, 0, 0, 1, 0, 0);
        repeat (3) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending predictions, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised inter-stage register for the pipelined MIPS CPU, the generic successor to the fixed-field EX/MEM register. It carries an opaque payload bundle plus the destination register, PC, delay-slot flag and exception code between two stages. It adds stall (hold), flush (bubble insertion), a valid bit, exception merging with write-back cancel, and saturating stall/bubble performance counters. One instance sits between each pair of stages: D/E, E/M and M/W.

## Interface
Parameters:
- DATA_W, 128, payload width (instr, rt, alu, ext, pc8, … packed by the instantiating stage)
- WBA_W, 5, write-back register address width
- CNT_W, 16, performance counter width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset); one clock, reset is asynchronous and active-low
- en  in  1  advance; 0 = stall (hold contents)
- flush  in  1  load a bubble this edge
- clr_cnt  in  1  synchronous clear of both counters
- in_valid  in  1  upstream slot holds a real instruction
- in_data  in  DATA_W  payload
- in_wba  in  WBA_W  destination register (0 = no write)
- in_pc  in  32  instruction PC
- in_bd  in  1  instruction is in a branch delay slot
- in_exc  in  5  exception code carried from earlier stages (0 = none)
- stage_exc  in  5  exception detected by the producing stage (0 = none)
- out_valid  out  1  registered in_valid
- out_data  out  DATA_W  registered payload
- out_wba  out  WBA_W  registered destination
- out_pc  out  32  registered PC
- out_bd  out  1  registered delay-slot flag
- out_exc  out  5  registered merged exception code
- stall_cnt  out  CNT_W  cycles held with a valid instruction
- bubble_cnt  out  CNT_W  bubbles loaded

## Operation
- Edge action priority: reset > flush > stall (en=0) > load.
- Reset (reset=0): every output is cleared to 0 immediately, without waiting for a clock edge. This includes out_pc, both counters, out_valid and out_exc. Reset held low keeps all outputs 0.
- Flush (flush=1, regardless of en):
  - out_valid, out_data, out_wba and out_exc are set to 0.
  - out_pc and out_bd load in_pc and in_bd, so a bubble still carries a valid EPC for an interrupt.
  - bubble_cnt increments.
- Stall (flush=0, en=0): all data outputs hold. stall_cnt increments only if out_valid=1.
- Load (flush=0, en=1):
  - out_valid <= in_valid.
  - out_pc <= in_pc; out_bd <= in_bd.
  - out_data <= in_valid ? in_data : 0.
  - Exception merge, earliest wins:
    - in_valid=0: exc = 0.
    - in_valid=1 and in_exc≠0: exc = in_exc.
    - otherwise: exc = stage_exc.
  - out_exc <= exc.
  - out_wba <= (in_valid && exc==0) ? in_wba : 0. A faulting instruction never writes back.
  - bubble_cnt increments when in_valid=0.
- Counters:
  - Both saturate at 2^CNT_W−1 and never wrap.
  - clr_cnt=1 sets both counters to 0 on the edge; clear wins over a same-cycle increment.
  - The counters advance during flush and stall exactly as described above, independent of clr_cnt on other cycles.
- Width rules: payload is passed through bit-exact; no sign or zero extension is done inside the block.

## Timing
- Latency is exactly 1 cycle, input edge to output. All outputs are driven straight from registers, with no combinational input-to-output path.
- Outputs change only on a rising clk edge or on reset falling.
- Reset deassertion (0→1) is synchronised by the top level. The first load takes place on the first rising edge with reset=1.
- Reset asserted mid-stall or mid-flush: outputs go to 0 at once, and the operation is abandoned.
- flush=1 with en=0 on the same edge: a bubble is loaded and stall_cnt does not increment.
- Back-to-back loads sustain one instruction per cycle; en=1 every cycle causes no bubbles.

## Test plan
- Reset: drive all inputs nonzero, pull reset=0 between clock edges → all outputs 0 before the next edge. Release, load in_valid=1, in_data=0xA5…A5, in_wba=8, in_pc=0x3000 → one edge later the outputs match those values and out_exc=0.
- Stall: load in_pc=0x3004, then hold en=0 for 3 edges while changing the inputs → outputs unchanged and stall_cnt=3. Raise en → the new inputs appear after 1 edge.
- Flush during stall: en=0, flush=1, in_pc=0x3010, in_bd=1 → out_valid=0, out_data=0, out_wba=0, out_exc=0, out_pc=0x3010, out_bd=1; bubble_cnt +1; stall_cnt unchanged.
- Exception merge:
  - in_exc=4, stage_exc=12, in_wba=9 → out_exc=4, out_wba=0.
  - in_exc=0, stage_exc=12 → out_exc=12, out_wba=0.
  - in_valid=0, stage_exc=12 → out_exc=0, out_valid=0.
- Saturation: with CNT_W=4, stall for 20 cycles with a valid instruction → stall_cnt stays at 15. Assert clr_cnt together with a stall → stall_cnt=0 on that edge.
